instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// holds the fetched word in a single output slot for decode, and handles
// PC redirects by discarding any response that belongs to the old stream.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // REQ: may issue; WAIT: response owed to current stream;
  // DROP: response owed to a stream a redirect has abandoned.
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  // The PC is always word aligned, so only the upper 30 bits are stored;
  // incrementing them wraps modulo 2^32 on the full address.
  logic [31:2] pc;
  logic        slot_free;
  logic        load;

  // Output slot can accept a new word if empty or being consumed this cycle.
  assign slot_free = !if_valid || if_ready;
  // A response is kept only if it belongs to the live stream and no redirect
  // arrives alongside it.
  assign load      = (state == WAIT) && imem_rvalid && !redirect;
  assign imem_addr = {pc, 2'b00};

  // Next-state and request logic.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      REQ: begin
        imem_req = slot_free && !rst;
        if (imem_req && imem_gnt) begin
          state_nxt = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Program counter: redirect wins, otherwise step past each kept word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC[31:2];
    end else if (redirect) begin
      pc <= redirect_pc[31:2];
    end else if (load) begin
      pc <= pc + 30'd1;
    end
  end

  // Output slot: load fetched word, hold under back-pressure, flush on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= RESET_PC;
      if_pc4   <= RESET_PC + 32'd4;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= {pc, 2'b00};
      if_pc4   <= {pc + 30'd1, 2'b00};
    end else if (if_valid && if_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule
